seq_mult8_ctrl: RTL and testbench

//   Sequential 8x8 unsigned shift-and-add multiplier controller built around the
//   8-bit CLA adder (eb_adder_top).

---
 rtl/seq_mult8_ctrl_if.sv | 36 +++
 rtl/seq_mult8_ctrl.sv | 123 ++++++++++++
 tb/tb_seq_mult8_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seq_mult8_ctrl_if.sv
// seq_mult8_ctrl_if
//   Bundles the request/response handshake of the sequential multiplier
//   together with the operand/result wires of the external 8-bit adder.
//   slave  : the multiplier controller side
//   master : the requester / adder side (drives start and operands, returns
//            the adder sum)
// Signals:
//   start, mcand, mplier   request and operands
//   busy, done, product    status and 16-bit result
//   add_a, add_b, add_cin  operands sent to the adder
//   add_y, add_cout        sum and carry returned by the adder
interface seq_mult8_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_y;
  logic               add_cout;

  modport slave (
    input  start, mcand, mplier, add_y, add_cout,
    output busy, done, product, add_a, add_b, add_cin
  );

  modport master (
    output start, mcand, mplier, add_y, add_cout,
    input  busy, done, product, add_a, add_b, add_cin
  );
endinterface

// File: rtl/seq_mult8_ctrl.sv
// seq_mult8_ctrl
//   Sequential 8x8 unsigned shift-and-add multiplier controller. One pass of
//   the external adder is used per multiplier bit; the adder result is
//   shifted right into a {acc, mq} register pair so that after WIDTH passes
//   the pair holds the full 2*WIDTH-bit product.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   seq_mult8_ctrl_if.slave: start/mcand/mplier request, busy/done/
//         product status, add_a/add_b/add_cin to the adder, add_y/add_cout
//         back from it.
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for start; done pulse is cleared on every IDLE edge
//   ST_RUN  | one adder pass per edge, WIDTH passes in total
module seq_mult8_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_mult8_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]   mq, mq_nxt;
  logic [WIDTH-1:0]   mc, mc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               busy, busy_nxt;
  logic               done, done_nxt;
  logic [2*WIDTH-1:0] product, product_nxt;

  // Partial product after this pass: the adder's 9-bit sum becomes the new
  // upper half and the retired multiplier bit drops off the bottom of mq.
  logic [2*WIDTH-1:0] shifted;

  assign shifted = {bus.add_cout, bus.add_y, mq[WIDTH-1:1]};

  // Adder drive is purely combinational from registers so it is valid in
  // every cycle, including IDLE.
  assign bus.add_a   = acc;
  assign bus.add_b   = mq[0] ? mc : '0;
  assign bus.add_cin = 1'b0;

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      mq      <= '0;
      mc      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      mq      <= mq_nxt;
      mc      <= mc_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      product <= product_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    mq_nxt      = mq;
    mc_nxt      = mc;
    cnt_nxt     = cnt;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    product_nxt = product;

    unique case (state)
      ST_IDLE: begin
        // Accepting here also covers the done cycle, so a held start gives
        // back-to-back runs separated by a single IDLE cycle.
        if (bus.start) begin
          mc_nxt    = bus.mcand;
          mq_nxt    = bus.mplier;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        {acc_nxt, mq_nxt} = shifted;
        cnt_nxt           = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          product_nxt = shifted;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_mult8_ctrl.sv
// tb_seq_mult8_ctrl
//   Directed and random operations against the multiplier controller. The
//   adder is modelled as plain addition on the interface; expected products
//   are mcand*mplier and expected timing is "busy for 8 cycles, then done".
module tb_seq_mult8_ctrl;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] held;

  seq_mult8_ctrl_if #(.WIDTH(8)) bus ();

  seq_mult8_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign {bus.add_cout, bus.add_y} = 9'(bus.add_a) + 9'(bus.add_b) + 9'(bus.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: start is presented, then the bench expects busy for
  // exactly 8 cycles and a done pulse carrying a*b.
  //   intr_at  : RUN cycle index at which to interfere (-1 = none)
  //   intr_rst : interfere with a reset instead of a second start
  //   chain    : leave start high so the next call is accepted on the done cycle
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int intr_at, input bit intr_rst, input bit chain);
    logic [15:0] exp;
    exp = 16'(a) * 16'(b);
    bus.mcand  = a;
    bus.mplier = b;
    bus.start  = 1'b1;
    tick;
    if (!chain) bus.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("done_run", 32'(bus.done), 32'd0);
      chk("prod_hold", 32'(bus.product), 32'(held));
      chk("cin_zero", 32'(bus.add_cin), 32'd0);
      if (c == intr_at) begin
        if (intr_rst) begin
          rst = 1'b1;
          tick;
          rst = 1'b0;
          chk("rst_busy", 32'(bus.busy), 32'd0);
          chk("rst_done", 32'(bus.done), 32'd0);
          chk("rst_prod", 32'(bus.product), 32'd0);
          held = 16'd0;
          for (int k = 0; k < 10; k++) begin
            tick;
            chk("rst_no_done", 32'(bus.done), 32'd0);
            chk("rst_idle", 32'(bus.busy), 32'd0);
          end
          return;
        end else begin
          bus.start  = 1'b1;
          bus.mcand  = 8'd7;
          bus.mplier = 8'd7;
        end
      end else if (!chain) begin
        bus.start = 1'b0;
      end
      if (chain) begin
        bus.mcand  = 8'($urandom);
        bus.mplier = 8'($urandom);
      end
      tick;
    end
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("product", 32'(bus.product), 32'(exp));
    held = exp;
    if (!chain) begin
      bus.start = 1'b0;
      tick;
      chk("done_clear", 32'(bus.done), 32'd0);
      chk("busy_idle", 32'(bus.busy), 32'd0);
      chk("prod_keep", 32'(bus.product), 32'(held));
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.mcand  = 8'd33;
    bus.mplier = 8'd44;
    held       = 16'd0;

    // Reset held with start high: nothing may start.
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_prod", 32'(bus.product), 32'd0);
      chk("reset_cin", 32'(bus.add_cin), 32'd0);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    tick;
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    run_op(8'd15,  8'd15,  -1, 1'b0, 1'b0);
    run_op(8'd100, 8'd50,  -1, 1'b0, 1'b0);
    run_op(8'd255, 8'd255, -1, 1'b0, 1'b0);
    run_op(8'd0,   8'd200, -1, 1'b0, 1'b0);
    run_op(8'd1,   8'd2,   -1, 1'b0, 1'b0);

    // Second start during RUN must be ignored.
    run_op(8'd15,  8'd15,  2, 1'b0, 1'b0);
    chk("ignored_start_idle", 32'(bus.busy), 32'd0);

    // Reset mid-run abandons the operation.
    run_op(8'd100, 8'd50,  3, 1'b1, 1'b0);
    run_op(8'd2,   8'd3,   -1, 1'b0, 1'b0);

    // Start held high: accepted on each done cycle, product held meanwhile.
    run_op(8'd9,   8'd9,   -1, 1'b0, 1'b1);
    run_op(8'd12,  8'd11,  -1, 1'b0, 1'b1);
    run_op(8'd3,   8'd5,   -1, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      bit         rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = (n != 23) && ($urandom_range(0, 2) == 0);
      run_op(ra, rb, -1, 1'b0, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
